// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcodes, select codes and the packed control vector.
package mips_multicycle_control_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] ula_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-unit <-> datapath bus: opcode/mem_ready in, control vector out.
interface mips_multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  import mips_multicycle_control_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                ula_src_a;
  logic [1:0]          ula_src_b;
  logic [1:0]          ula_op;
  logic [1:0]          pc_source;
  logic [STATE_W-1:0]  state;
  logic                illegal_op;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, ula_src_a, ula_src_b, ula_op,
           pc_source, state, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, ula_src_a, ula_src_b, ula_op,
           pc_source, state, illegal_op, instr_count
  );

endinterface

// File: rtl/mips_multicycle_control_decode.sv
// Combinational decode of (state, mem_ready, reset) into the control vector.
// The JUMP state decode exists only when MIPS_JUMP_EN is defined.
module mips_multicycle_control_decode
  import mips_multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ula_src_b = SRC_B_FOUR;
        ctrl.ula_op    = ULA_ADD;
        ctrl.pc_source = PC_SRC_ULA;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.ula_src_b = SRC_B_IMM_SH2;
        ctrl.ula_op    = ULA_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRC_B_IMM;
        ctrl.ula_op    = ULA_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRC_B_REG;
        ctrl.ula_op    = ULA_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.ula_src_a     = 1'b1;
        ctrl.ula_src_b     = SRC_B_REG;
        ctrl.ula_op        = ULA_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_BRANCH;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`ifdef MIPS_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
`endif
      default: ctrl = '0;
    endcase

    // Reset suppresses every architectural write strobe in the same cycle.
    if (reset) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.reg_write     = 1'b0;
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore FSM, memory-stall handling and a
// retired-instruction counter. Jump support is enabled by MIPS_JUMP_EN.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  mips_multicycle_control_if.master   bus
);

  state_t           state_q;
  state_t           state_d;
  logic             illegal_c;
  logic             retire_c;
  logic [CNT_W-1:0] count_q;
  ctrl_t            ctrl;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; retire_c flags a counted return to FETCH
  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    retire_c  = 1'b0;
    case (state_q)
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MIPS_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_EXEC:    state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
`ifdef MIPS_JUMP_EN
      S_JUMP: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset)         count_q <= '0;
    else if (retire_c) count_q <= count_q + CNT_W'(1);
  end

  // Output decode
  mips_multicycle_control_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.ula_src_a     = ctrl.ula_src_a;
  assign bus.ula_src_b     = ctrl.ula_src_b;
  assign bus.ula_op        = ctrl.ula_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.state         = state_q;
  assign bus.illegal_op    = illegal_c & ~reset;
  assign bus.instr_count   = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: vector table, directed corner cases and
// randomized traffic against an instruction-level phase-list model.
module tb_mips_multicycle_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mips_multicycle_control_if #(.CNT_W(32)) bus ();

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [5:0] op;
    bit         chk;
    int         st;
    bit         rw;
    bit         mw;
    bit         irw;
    bit         ill;
    int         cnt;
  } vec_t;

  vec_t vecs[15];

  int n_chk  = 0;
  int n_fail = 0;

  // Instruction-level model: each instruction is a list of visited states
  int          m_ph[6];
  int          m_len;
  int          m_idx;
  bit          m_new   = 1'b1;
  bit          m_valid = 1'b0;
  bit          m_legal;
  logic [31:0] m_count = '0;
  logic [5:0]  m_next_op = 6'h00;

  logic [15:0] ctl_tab[12];
  int obs_mw, obs_pcwc, obs_ill;

  localparam logic [15:0] STROBE_MASK = 16'hCC80;
  localparam logic [15:0] FETCH_RDY   = 16'h8400;

  function automatic vec_t mkv(logic rst, logic rdy, logic [5:0] op, bit chk,
                               int st, bit rw, bit mw, bit irw, bit ill, int cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.op = op; v.chk = chk; v.st = st;
    v.rw = rw; v.mw = mw; v.irw = irw; v.ill = ill; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [15:0] ctl(bit pcw, bit pcwc, bit iord, bit mr, bit mw,
                                      bit irw, bit m2r, bit rd, bit rw, bit sa,
                                      logic [1:0] sb, logic [1:0] uop, logic [1:0] ps);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, uop, ps};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_phases(input logic [5:0] op);
    m_ph[0] = 0; m_ph[1] = 1; m_legal = 1'b1;
    case (op)
      6'h00: begin m_ph[2] = 6;  m_ph[3] = 7;  m_len = 4; end
      6'h23: begin m_ph[2] = 2;  m_ph[3] = 3;  m_ph[4] = 4; m_len = 5; end
      6'h2B: begin m_ph[2] = 2;  m_ph[3] = 5;  m_len = 4; end
      6'h04: begin m_ph[2] = 8;  m_len = 3; end
      6'h08: begin m_ph[2] = 10; m_ph[3] = 11; m_len = 4; end
`ifdef MIPS_JUMP_EN
      6'h02: begin m_ph[2] = 9;  m_len = 3; end
`endif
      default: begin m_len = 2; m_legal = 1'b0; end
    endcase
  endtask

  // One clock cycle: drive, check against the model, clock, advance the model
  task automatic cycle(input logic rdy, input logic rst, input string tag);
    logic [15:0] exp_ctl, act_ctl;
    int st;
    if (m_new) begin
      bus.opcode = m_next_op;
      set_phases(m_next_op);
      m_idx = 0;
      m_new = 1'b0;
    end
    bus.mem_ready = rdy;
    reset = rst;
    #1;
    act_ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
               bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
               bus.reg_write, bus.ula_src_a, bus.ula_src_b, bus.ula_op, bus.pc_source};
    if (m_valid) begin
      st = m_ph[m_idx];
      exp_ctl = ctl_tab[st];
      if (st == 0 && rdy) exp_ctl = exp_ctl | FETCH_RDY;
      if (rst) exp_ctl = exp_ctl & ~STROBE_MASK;
      chk({tag, "_state"}, 32'(bus.state), 32'(st));
      chk({tag, "_ctl"}, 32'(act_ctl), 32'(exp_ctl));
      chk({tag, "_illegal"}, 32'(bus.illegal_op), 32'(st == 1 && !m_legal && !rst));
      chk({tag, "_count"}, bus.instr_count, m_count);
    end
    obs_mw   += int'(bus.mem_write);
    obs_pcwc += int'(bus.pc_write_cond && bus.pc_source == 2'b01);
    obs_ill  += int'(bus.illegal_op);
    @(posedge clock);
    #1;
    if (rst) begin
      m_count = '0;
      m_new   = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      st = m_ph[m_idx];
      if (!((st == 0 || st == 3 || st == 5) && !rdy)) begin
        m_idx++;
        if (m_idx == m_len) begin
          if (m_legal) m_count = m_count + 32'd1;
          m_new = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input logic [5:0] op, input int n, input logic [15:0] rdy_pat,
                     input string tag);
    m_next_op = op;
    for (int i = 0; i < n; i++) cycle(rdy_pat[i], 1'b0, tag);
  endtask

  logic [31:0] c0;
  logic [5:0]  ops[6];

  initial begin
    ctl_tab[0]  = ctl(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
    ctl_tab[1]  = ctl(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
    ctl_tab[2]  = ctl(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    ctl_tab[3]  = ctl(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    ctl_tab[4]  = ctl(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
    ctl_tab[5]  = ctl(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
    ctl_tab[6]  = ctl(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
    ctl_tab[7]  = ctl(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    ctl_tab[8]  = ctl(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
    ctl_tab[9]  = ctl(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
    ctl_tab[10] = ctl(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    ctl_tab[11] = ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h02;

    //               rst rdy op    chk st rw mw irw ill cnt
    vecs[0]  = mkv(1, 1, 6'h00, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 1, 6'h00, 1, 0,  0, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 1, 6'h00, 1, 0,  0, 0, 1, 0, 0);
    vecs[3]  = mkv(0, 1, 6'h00, 1, 1,  0, 0, 0, 0, 0);
    vecs[4]  = mkv(0, 1, 6'h00, 1, 6,  0, 0, 0, 0, 0);
    vecs[5]  = mkv(0, 1, 6'h00, 1, 7,  1, 0, 0, 0, 0);
    vecs[6]  = mkv(0, 1, 6'h3F, 1, 0,  0, 0, 1, 0, 1);
    vecs[7]  = mkv(0, 1, 6'h3F, 1, 1,  0, 0, 0, 1, 1);
    vecs[8]  = mkv(0, 0, 6'h08, 1, 0,  0, 0, 0, 0, 1);
    vecs[9]  = mkv(0, 0, 6'h08, 1, 0,  0, 0, 0, 0, 1);
    vecs[10] = mkv(0, 1, 6'h08, 1, 0,  0, 0, 1, 0, 1);
    vecs[11] = mkv(0, 1, 6'h08, 1, 1,  0, 0, 0, 0, 1);
    vecs[12] = mkv(0, 1, 6'h08, 1, 10, 0, 0, 0, 0, 1);
    vecs[13] = mkv(0, 1, 6'h08, 1, 11, 1, 0, 0, 0, 1);
    vecs[14] = mkv(0, 1, 6'h08, 1, 0,  0, 0, 1, 0, 2);

    bus.opcode = 6'h00;
    bus.mem_ready = 1'b1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus.mem_ready = vecs[i].rdy;
      bus.opcode = vecs[i].op;
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
        chk($sformatf("vec%0d_reg_write", i), 32'(bus.reg_write), 32'(vecs[i].rw));
        chk($sformatf("vec%0d_mem_write", i), 32'(bus.mem_write), 32'(vecs[i].mw));
        chk($sformatf("vec%0d_ir_write", i), 32'(bus.ir_write), 32'(vecs[i].irw));
        chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal_op), 32'(vecs[i].ill));
        chk($sformatf("vec%0d_count", i), bus.instr_count, 32'(vecs[i].cnt));
      end
      @(posedge clock);
      #1;
    end

    // Model-tracked directed sequences
    cycle(1'b1, 1'b1, "rst");
    cycle(1'b1, 1'b1, "rst");

    c0 = bus.instr_count;
    run(6'h23, 8, 16'b1100_0111, "lw");
    chk("lw_end_state", 32'(bus.state), 32'd0);
    chk("lw_count", bus.instr_count, c0 + 32'd1);

    obs_mw = 0; obs_pcwc = 0; c0 = bus.instr_count;
    run(6'h2B, 4, 16'hFFFF, "sw");
    run(6'h04, 3, 16'hFFFF, "beq");
    chk("sw_mem_write_cycles", 32'(obs_mw), 32'd1);
    chk("beq_cond_cycles", 32'(obs_pcwc), 32'd1);
    chk("sw_beq_count", bus.instr_count, c0 + 32'd2);

    obs_ill = 0; c0 = bus.instr_count;
    run(6'h3F, 2, 16'hFFFF, "ill");
    chk("ill_pulses", 32'(obs_ill), 32'd1);
    chk("ill_count", bus.instr_count, c0);
    chk("ill_state", 32'(bus.state), 32'd0);

    obs_ill = 0; c0 = bus.instr_count;
`ifdef MIPS_JUMP_EN
    run(6'h02, 3, 16'hFFFF, "j");
    chk("j_pulses", 32'(obs_ill), 32'd0);
    chk("j_count", bus.instr_count, c0 + 32'd1);
`else
    run(6'h02, 2, 16'hFFFF, "j");
    chk("j_pulses", 32'(obs_ill), 32'd1);
    chk("j_count", bus.instr_count, c0);
`endif

    run(6'h2B, 4, 16'b0111, "sw_stall");
    chk("sw_stall_mem_write", 32'(bus.mem_write), 32'd1);
    cycle(1'b0, 1'b1, "sw_rst");
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_count", bus.instr_count, 32'd0);
    cycle(1'b1, 1'b0, "post_rst");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 6);
      m_next_op = (r < 6) ? ops[r] : 6'($urandom);
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 149) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS datapath, sitting directly upstream of the datapath and driving every mux select, write enable, and ULA-operation code it consumes. A Moore state machine sequences each instruction through fetch, decode, execute, memory, and write-back. It stalls on memory accesses until the shared instruction/data memory signals completion, and it counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if the ULA zero flag is set (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ula_result
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back data select: 0 = ULA, 1 = MDR
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- ula_src_a  out  1  operand A select: 0 = PC, 1 = register A
- ula_src_b  out  2  operand B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ula_op  out  2  code to ula_control: 00 = add, 01 = sub, 10 = funct
- pc_source  out  2  next-PC select: 00 = ULA, 01 = branch target, 10 = jump target
- state  out  4  current state encoding (debug)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- instr_count  out  CNT_W  retired instructions

## Operation
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11.
- FETCH asserts mem_read, i_or_d=0, ula_src_a=0, ula_src_b=01, ula_op=00, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1. The FSM then moves to DECODE; otherwise it holds in FETCH.
- DECODE asserts ula_src_a=0, ula_src_b=11, ula_op=00 (branch target precompute), then dispatches on opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x08 → ADDI_EX
  - 0x02 → JUMP (see Configuration)
  - any other opcode → FETCH, with illegal_op pulsed for 1 cycle
- MEM_ADDR asserts ula_src_a=1, ula_src_b=10, ula_op=00. It goes to MEM_RD for lw (0x23) and to MEM_WR for sw (0x2B).
- MEM_RD asserts mem_read and i_or_d=1. It holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB asserts reg_write, mem_to_reg=1, reg_dst=0, then returns to FETCH.
- MEM_WR asserts mem_write and i_or_d=1. It holds until mem_ready=1, then returns to FETCH.
  - mem_write stays high for every cycle spent in MEM_WR.
- EXEC asserts ula_src_a=1, ula_src_b=00, ula_op=10, then goes to R_WB.
- R_WB asserts reg_write, reg_dst=1, mem_to_reg=0, then returns to FETCH.
- BRANCH asserts ula_src_a=1, ula_src_b=00, ula_op=01, pc_write_cond, pc_source=01, then returns to FETCH.
- ADDI_EX asserts ula_src_a=1, ula_src_b=10, ula_op=00, then goes to ADDI_WB.
- ADDI_WB asserts reg_write, reg_dst=0, mem_to_reg=0, then returns to FETCH.
- JUMP asserts pc_write and pc_source=10, then returns to FETCH.
- Outputs not listed for a state are 0.
- instr_count increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, ADDI_WB, or JUMP.
  - It does not increment on the illegal-opcode return.
  - It wraps modulo 2^CNT_W.

## Timing
- The state register and instr_count update on the rising clock edge.
- All control outputs are a combinational decode of the registered state; FETCH and the memory states also depend on mem_ready.
- Reset, while reset=1:
  - On the next edge: state=FETCH, instr_count=0.
  - Combinationally: pc_write, pc_write_cond, ir_write, mem_write, reg_write, and illegal_op are forced to 0.
- Reset asserted mid-instruction aborts it: no write strobe fires after the asserting edge, and the instruction is not counted.
- Cycles per instruction with mem_ready held at 1: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5.
  - Each cycle mem_ready is low in FETCH, MEM_RD, or MEM_WR adds one cycle.
- An illegal opcode costs 2 cycles: FETCH, then DECODE.
- mem_ready is ignored in every state other than FETCH, MEM_RD, and MEM_WR.

## Configuration
- The macro MIPS_JUMP_EN controls jump support.
- Defined: opcode 0x02 dispatches DECODE → JUMP, and pc_source may take the value 10.
- Undefined: the JUMP state is not compiled, opcode 0x02 is treated as illegal (illegal_op pulse, return to FETCH, not counted), and pc_source never takes the value 10.

## Structure
- A shared package header (mips_defs.v) holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ula_op codes
  - ula_src_b and pc_source select codes
- One natural sub-module, mips_ctrl_decode: a purely combinational decoder from (state, mem_ready, reset) to the control vector.
- The top level holds the state register, the next-state logic, and instr_count.

## Test plan
- Reset held 2 cycles, then released with mem_ready=1 and an R-type opcode 0x00 → states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_count=1.
- lw 0x23 with mem_ready low for 3 cycles in MEM_RD → states 0,1,2,3,3,3,3,4,0 (8 cycles); mem_read high in all four MEM_RD cycles; mem_to_reg=1 only in state 4.
- sw 0x2B then beq 0x04, mem_ready=1 → mem_write high for exactly 1 cycle; pc_write_cond with pc_source=01 for 1 cycle; instr_count advances by 2 over 7 cycles.
- Opcode 0x3F → illegal_op high for 1 cycle in DECODE; next state FETCH; instr_count unchanged.
- Opcode 0x02: with MIPS_JUMP_EN defined → states 0,1,9,0, pc_write with pc_source=10; without it → illegal_op pulse.
- Reset asserted during MEM_WR with mem_ready=0 → mem_write drops to 0 in the same cycle; the next state is FETCH and instr_count=0.
